api_tx_arb: RTL and testbench

- Round-robin scheduler that shares the API TX FIFO between NREQ work sources (e.g. CPU bus writer and on-chip work generator).
- Grants one source at a time for a whole work packet of WORK_LEN 32-bit words, so packets never interleave in the FIFO.
- Grants only when the FIFO has room for a full packet.
- Sits upstream of the API TX FIFO that feeds the API chain controller/PHY.

---
 rtl/api_tx_arb_pkg.sv | 27 ++
 rtl/api_tx_arb_if.sv | 31 +++
 rtl/api_rr_pick.sv | 39 +++
 rtl/api_tx_arb.sv | 140 ++++++++++++++
 tb/tb_api_tx_arb.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/api_tx_arb_pkg.sv
// Shared constants, FSM state type and helpers for the API TX arbiter.
// No logic of its own; imported by the interface, picker and arbiter.
// Defaults mirror the API TX FIFO geometry (23-word packets, 512-word FIFO).
package api_tx_arb_pkg;

  localparam int API_WORK_LEN      = 23;   // 736-bit work packet / 32
  localparam int API_TX_FIFO_DEPTH = 512;
  localparam int API_TX_CNT_W      = 10;
  localparam int API_WORD_W        = 32;
  localparam int API_MAX_REQ       = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_t;

  // Index of the set bit in a one-hot vector (0 when empty).
  function automatic logic [2:0] onehot_to_idx(input logic [API_MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < API_MAX_REQ; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/api_tx_arb_if.sv
// Bundle between the work sources / TX FIFO and the arbiter.
// slave: arbiter view (sources in, FIFO write + status out); master: environment view.
// Per-source words move on req_vld & req_rdy; FIFO side is a plain write strobe.
interface api_tx_arb_if
  import api_tx_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int CNT_W = API_TX_CNT_W
);

  logic [NREQ-1:0]            req_vld;
  logic [API_WORD_W*NREQ-1:0] req_dat;
  logic [NREQ-1:0]            req_rdy;
  logic                       tx_fifo_wr_en;
  logic [API_WORD_W-1:0]      tx_fifo_din;
  logic [CNT_W-1:0]           tx_fifo_data_count;
  logic [NREQ-1:0]            grant;
  logic                       busy;
  logic [15:0]                pkt_cnt;

  modport slave (
    input  req_vld, req_dat, tx_fifo_data_count,
    output req_rdy, tx_fifo_wr_en, tx_fifo_din, grant, busy, pkt_cnt
  );

  modport master (
    output req_vld, req_dat, tx_fifo_data_count,
    input  req_rdy, tx_fifo_wr_en, tx_fifo_din, grant, busy, pkt_cnt
  );

endinterface

// File: rtl/api_rr_pick.sv
// Cyclic priority picker: first asserted req at or after ptr, wrapping.
// Purely combinational, zero latency; no backpressure.
// Ports: req (requests), ptr (start index, < NREQ), gnt (one-hot), any (some req set).
module api_rr_pick
  import api_tx_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic             any
);

  logic [2*NREQ-1:0] dbl;
  int                off;
  int                sel;

  always_comb begin
    // Rotating a doubled copy puts ptr at bit 0, so the lowest set bit is the winner.
    dbl = {req, req} >> ptr;
    off = 0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (dbl[k]) begin
        off = k;
        any = 1'b1;
      end
    end
    sel = int'(ptr) + off;
    if (sel >= NREQ) sel = sel - NREQ;
    gnt = '0;
    for (int j = 0; j < NREQ; j++) begin
      gnt[j] = any && (sel == j);
    end
  end

endmodule

// File: rtl/api_tx_arb.sv
// Round-robin packet scheduler sharing the API TX FIFO between NREQ work sources.
// Latency: grant 1 cycle after the IDLE decision; data path req -> FIFO is combinational.
// Backpressure: only grants with a full packet of FIFO room; owner may stall freely, no timeout.
// Ports: clk, rst (async), reg_rst (sync soft reset); bus: req_vld/req_dat/req_rdy per source,
//        tx_fifo_wr_en/tx_fifo_din/tx_fifo_data_count, grant (one-hot owner), busy, pkt_cnt.
module api_tx_arb
  import api_tx_arb_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int WORK_LEN   = API_WORK_LEN,
  parameter int FIFO_DEPTH = API_TX_FIFO_DEPTH,
  parameter int CNT_W      = API_TX_CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          reg_rst,
  api_tx_arb_if.slave   bus
);

  localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WCNT_W = $clog2(WORK_LEN + 1);

  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORK_LEN - 1);
  localparam logic [CNT_W:0]    DEPTH_X   = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W:0]    NEED_X    = (CNT_W + 1)'(WORK_LEN);

  arb_state_t              state_q;
  arb_state_t              state_d;
  logic [NREQ-1:0]         grant_q;
  logic [PTR_W-1:0]        own_idx;
  logic [PTR_W-1:0]        rr_ptr;
  logic [WCNT_W-1:0]       word_cnt;
  logic [15:0]             pkt_cnt_q;

  logic [NREQ-1:0]         pick_gnt;
  logic                    pick_any;
  logic [CNT_W:0]          cnt_x;
  logic                    space_ok;
  logic                    own_vld;
  logic [API_WORD_W-1:0]   own_dat;
  logic                    start;
  logic                    take;
  logic                    last_word;

  api_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req (bus.req_vld),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .any (pick_any)
  );

  // Occupancy can exceed the nominal depth on a bad count; treat that as no room
  // instead of letting the subtraction wrap.
  assign cnt_x    = {1'b0, bus.tx_fifo_data_count};
  assign space_ok = (cnt_x <= DEPTH_X) && ((DEPTH_X - cnt_x) >= NEED_X);

  // Only the owner's lane reaches the FIFO; grant_q is zero outside XFER.
  assign own_vld = |(bus.req_vld & grant_q);

  always_comb begin
    own_dat = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant_q[j]) own_dat = own_dat | bus.req_dat[API_WORD_W*j +: API_WORD_W];
    end
  end

  assign start     = (state_q == ST_IDLE) && pick_any && space_ok;
  assign take      = (state_q == ST_XFER) && own_vld;
  assign last_word = take && (word_cnt == LAST_WORD);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else if (reg_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_any && space_ok) state_d = ST_XFER;
      ST_XFER: if (last_word)            state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // Outputs. reg_rst also drops req_rdy so a source never sees a word
  // accepted that was not written.
  always_comb begin
    bus.req_rdy       = '0;
    bus.tx_fifo_wr_en = 1'b0;
    if ((state_q == ST_XFER) && !reg_rst) begin
      bus.req_rdy       = grant_q;
      bus.tx_fifo_wr_en = own_vld;
    end
    bus.tx_fifo_din = own_dat;
    bus.grant       = grant_q;
    bus.busy        = (state_q == ST_XFER);
    bus.pkt_cnt     = pkt_cnt_q;
  end

  // Owner, word counter, round-robin pointer and packet counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q   <= '0;
      own_idx   <= '0;
      rr_ptr    <= '0;
      word_cnt  <= '0;
      pkt_cnt_q <= '0;
    end else if (reg_rst) begin
      grant_q   <= '0;
      own_idx   <= '0;
      rr_ptr    <= '0;
      word_cnt  <= '0;
      pkt_cnt_q <= '0;
    end else if (start) begin
      grant_q  <= pick_gnt;
      own_idx  <= PTR_W'(onehot_to_idx(API_MAX_REQ'(pick_gnt)));
      word_cnt <= '0;
    end else if (take) begin
      if (last_word) begin
        grant_q   <= '0;
        word_cnt  <= '0;
        rr_ptr    <= (own_idx == PTR_W'(NREQ - 1)) ? '0 : own_idx + PTR_W'(1);
        pkt_cnt_q <= pkt_cnt_q + 16'd1;
      end else begin
        word_cnt <= word_cnt + WCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_api_tx_arb.sv
module tb_api_tx_arb;
  import api_tx_arb_pkg::*;

  localparam int NREQ  = 2;
  localparam int WL    = 23;
  localparam int DEPTH = 512;
  localparam int CW    = 10;
  localparam int DW    = 32 * NREQ;

  logic clk = 1'b0;
  logic rst;
  logic reg_rst;
  always #5 clk = ~clk;

  api_tx_arb_if #(.NREQ(NREQ), .CNT_W(CW)) bus ();

  api_tx_arb #(
    .NREQ(NREQ), .WORK_LEN(WL), .FIFO_DEPTH(DEPTH), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .reg_rst(reg_rst), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Stimulus queues (driver) and reference copies (model), per source.
  logic [31:0] dq [NREQ][$];
  logic [31:0] mq [NREQ][$];
  logic [31:0] exp_q [$];
  int          dut_log [$];
  int          sent [NREQ];
  int          stall_at [NREQ];
  int          stall_cnt [NREQ];
  bit          take [NREQ];
  int          stall_pct = 0;
  int          wr_total = 0;
  logic [NREQ-1:0] prev_g = '0;

  // Reference model state: who owns the FIFO, how far along, RR pointer, packets.
  bit          m_busy = 1'b0;
  int          m_owner = 0;
  int          m_ptr = 0;
  int          m_words = 0;
  logic [15:0] m_pkts = '0;
  int          m_c;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit bitof(input logic [NREQ-1:0] v, input int i);
    return ((v >> i) & NREQ'(1)) != '0;
  endfunction

  function automatic int idx_of(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (bitof(v, i)) r = i;
    return r;
  endfunction

  function automatic bit has_room(input int cnt);
    return (DEPTH - cnt) >= WL;
  endfunction

  function automatic bit all_drained();
    bit d = 1'b1;
    for (int i = 0; i < NREQ; i++) if (dq[i].size() != 0) d = 1'b0;
    return d && !m_busy && (exp_q.size() == 0) && !bus.busy;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_pkt(input int src);
    logic [31:0] w;
    for (int k = 0; k < WL; k++) begin
      w = $urandom;
      dq[src].push_back(w);
      mq[src].push_back(w);
    end
  endtask

  task automatic wait_idle(input int budget, input bit rnd_cnt);
    int n = 0;
    while (!all_drained()) begin
      if (n >= budget) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout: still active after %0d cycles, required idle", budget);
        return;
      end
      if (rnd_cnt) bus.tx_fifo_data_count = CW'($urandom_range(470, 520));
      tick();
      n++;
    end
  endtask

  task automatic wait_grant(input logic [NREQ-1:0] g, input int budget);
    int n = 0;
    while (bus.grant !== g) begin
      if (n >= budget) begin
        checks++;
        errors++;
        $display("FAIL grant_timeout: grant 0x%0h, required 0x%0h", bus.grant, g);
        return;
      end
      tick();
      n++;
    end
  endtask

  // Source drivers: hold each word until accepted, optional random/forced stalls.
  initial begin
    logic [NREQ-1:0] vld_v;
    logic [DW-1:0]   dat_v;
    for (int i = 0; i < NREQ; i++) begin
      sent[i] = 0;
      stall_at[i] = -1;
      stall_cnt[i] = 0;
    end
    bus.req_vld = '0;
    bus.req_dat = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) take[i] = bitof(bus.req_vld & bus.req_rdy, i);
      @(posedge clk);
      #1;
      vld_v = '0;
      dat_v = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (take[i] && dq[i].size() > 0) begin
          void'(dq[i].pop_front());
          sent[i]++;
          if (sent[i] == stall_at[i]) stall_cnt[i] = 10;
        end
        if (stall_cnt[i] > 0) begin
          stall_cnt[i]--;
        end else if (dq[i].size() > 0 && $urandom_range(0, 99) >= stall_pct) begin
          vld_v = vld_v | (NREQ'(1) << i);
          dat_v = dat_v | (DW'(dq[i][0]) << (32 * i));
        end
      end
      bus.req_vld = vld_v;
      bus.req_dat = dat_v;
    end
  end

  // Monitor + scoreboard: compare this cycle's outputs, then advance the model.
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_g;
    bit own_v;
    bit exp_wr;
    exp_g  = m_busy ? (NREQ'(1) << m_owner) : '0;
    own_v  = (bus.req_vld & exp_g) != '0;
    exp_wr = own_v && !reg_rst;
    check("grant", bus.grant, exp_g);
    check("busy", bus.busy, m_busy);
    check("req_rdy", bus.req_rdy, reg_rst ? '0 : exp_g);
    check("wr_en", bus.tx_fifo_wr_en, exp_wr);
    if (exp_wr && bus.tx_fifo_wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL din: write 0x%0h with no expected word", bus.tx_fifo_din);
      end else begin
        check("din", bus.tx_fifo_din, exp_q.pop_front());
      end
    end
    check("pkt_cnt", bus.pkt_cnt, m_pkts);
    if (bus.tx_fifo_wr_en) wr_total++;
    if (bus.grant != '0 && prev_g == '0) dut_log.push_back(idx_of(bus.grant));
    prev_g = bus.grant;

    if (rst || reg_rst) begin
      m_busy  = 1'b0;
      m_ptr   = 0;
      m_words = 0;
      m_pkts  = '0;
      exp_q.delete();
    end else if (!m_busy) begin
      if (bus.req_vld != '0 && has_room(int'(bus.tx_fifo_data_count))) begin
        for (int k = 0; k < NREQ; k++) begin
          m_c = (m_ptr + k) % NREQ;
          if (!m_busy && bitof(bus.req_vld, m_c)) begin
            m_busy  = 1'b1;
            m_owner = m_c;
          end
        end
        m_words = 0;
        for (int k = 0; k < WL; k++)
          if (mq[m_owner].size() > 0) exp_q.push_back(mq[m_owner].pop_front());
      end
    end else if (own_v) begin
      m_words++;
      if (m_words == WL) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % NREQ;
        m_pkts = m_pkts + 16'd1;
      end
    end
  end

  initial begin
    int w0;
    int base;
    int n;
    rst = 1'b1;
    reg_rst = 1'b0;
    bus.tx_fifo_data_count = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_grant", bus.grant, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_req_rdy", bus.req_rdy, 0);
    check("rst_wr_en", bus.tx_fifo_wr_en, 0);
    check("rst_pkt_cnt", bus.pkt_cnt, 0);

    // Single source, continuous valid.
    w0 = wr_total;
    push_pkt(0);
    wait_idle(300, 0);
    check("single_words", wr_total - w0, WL);
    check("single_pkt_cnt", bus.pkt_cnt, 1);
    check("single_grant_idle", bus.grant, 0);

    // Soft reset mid-test.
    reg_rst = 1'b1;
    #1;
    check("regrst_rdy", bus.req_rdy, 0);
    check("regrst_wr_en", bus.tx_fifo_wr_en, 0);
    tick();
    reg_rst = 1'b0;
    check("regrst_pkt_cnt", bus.pkt_cnt, 0);
    check("regrst_grant", bus.grant, 0);
    check("regrst_busy", bus.busy, 0);

    // Fairness: both sources saturated for four packets.
    base = dut_log.size();
    push_pkt(0); push_pkt(0); push_pkt(1); push_pkt(1);
    wait_idle(600, 0);
    check("fair_n", dut_log.size() - base, 4);
    for (int k = 0; k < 4; k++)
      if (base + k < dut_log.size()) check($sformatf("fair_order%0d", k), dut_log[base + k], k % 2);
    check("fair_pkt_cnt", bus.pkt_cnt, 4);

    // Space gate at the 23-free-slot boundary.
    bus.tx_fifo_data_count = CW'(490);
    push_pkt(0);
    repeat (10) tick();
    check("gate490_grant", bus.grant, 0);
    check("gate490_busy", bus.busy, 0);
    bus.tx_fifo_data_count = CW'(489);
    tick();
    check("gate489_grant", bus.grant, 2'b01);
    wait_idle(200, 0);
    bus.tx_fifo_data_count = '0;

    // Owner stall: source 1 goes quiet for 10 cycles after word 5.
    w0 = wr_total;
    base = dut_log.size();
    push_pkt(1);
    wait_grant(2'b10, 50);
    stall_at[1] = sent[1] + 5;
    push_pkt(0);
    n = 0;
    while (sent[1] != stall_at[1] && n < 100) begin
      tick();
      n++;
    end
    check("stall_reached", sent[1], stall_at[1]);
    for (int k = 0; k < 10; k++) begin
      check("stall_no_wr", bus.tx_fifo_wr_en, 0);
      check("stall_grant", bus.grant, 2'b10);
      tick();
    end
    stall_at[1] = -1;
    wait_idle(400, 0);
    check("stall_words", wr_total - w0, 2 * WL);
    if (dut_log.size() >= base + 2) begin
      check("stall_first", dut_log[base], 1);
      check("stall_second", dut_log[base + 1], 0);
    end
    check("stall_pkt_cnt", bus.pkt_cnt, 7);

    // Abort at word 12; pointer returns to 0 so source 0 wins the tie afterwards.
    push_pkt(0);
    wait_grant(2'b01, 50);
    n = 0;
    while (!(m_busy && m_words == 12) && n < 100) begin
      tick();
      n++;
    end
    check("abort_reached", m_words, 12);
    reg_rst = 1'b1;
    dq[0].delete();
    mq[0].delete();
    #1;
    check("abort_no_wr", bus.tx_fifo_wr_en, 0);
    check("abort_rdy", bus.req_rdy, 0);
    tick();
    reg_rst = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_grant", bus.grant, 0);
    check("abort_pkt_cnt", bus.pkt_cnt, 0);
    w0 = wr_total;
    base = dut_log.size();
    push_pkt(1); push_pkt(0);
    wait_idle(400, 0);
    if (dut_log.size() >= base + 2) begin
      check("abort_next0", dut_log[base], 0);
      check("abort_next1", dut_log[base + 1], 1);
    end
    check("abort_words", wr_total - w0, 2 * WL);
    check("abort_after_pkt_cnt", bus.pkt_cnt, 2);

    // Randomised traffic: random sources, valid gaps and FIFO occupancy.
    w0 = wr_total;
    stall_pct = 30;
    for (int k = 0; k < 12; k++) push_pkt(int'($urandom_range(0, NREQ - 1)));
    wait_idle(6000, 1);
    stall_pct = 0;
    bus.tx_fifo_data_count = '0;
    check("rand_words", wr_total - w0, 12 * WL);
    check("rand_pkt_cnt", bus.pkt_cnt, 14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
